// File: rtl/shiftreg_seq_ctrl_pkg.sv
// Shared types for the shift-register command sequencer: opcodes, shiftreg
// mode encodings and controller FSM states.
package shiftreg_seq_ctrl_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 3'b000,
        OP_CLR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // {s1,s0} encodings understood by the shiftreg datapath
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_load_op(input op_e op);
        return (op == OP_LOAD) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/shiftreg_seq_ctrl_if.sv
// Command/status bundle between a command issuer (master) and the
// shift-register sequencer (slave).
interface shiftreg_seq_ctrl_if
    import shiftreg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] q;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
        input  cmd_ready, busy, done, err, q
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
        output cmd_ready, busy, done, err, q
    );

endinterface

// File: rtl/shiftreg_seq_ctrl_shiftreg.sv
// Universal shift register: hold, shift right, shift left or parallel load
// selected by {s1,s0}. It has no reset; the controller clears it by loading 0.
module shiftreg_seq_ctrl_shiftreg
    import shiftreg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic             s1,
    input  logic             s0,
    input  logic             clk,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk) begin
        case (mode_e'({s1, s0}))
            MODE_SHR:  data_out <= {MSB_in, data_out[WIDTH-1:1]};
            MODE_SHL:  data_out <= {data_out[WIDTH-2:0], LSB_in};
            MODE_LOAD: data_out <= data_in;
            default:   data_out <= data_out;
        endcase
    end

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Command sequencer for the universal shift register: accepts one opcode+count
// command per handshake and steps the register the requested number of times.
module shiftreg_seq_ctrl
    import shiftreg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    shiftreg_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    op_e              op_q;
    op_e              cmd_op_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             fill_q;
    logic             accept;

    mode_e            mode;
    logic [WIDTH-1:0] sr_data_in;
    logic             msb_in;
    logic             lsb_in;
    logic [WIDTH-1:0] sr_q;

    assign cmd_op_e = op_e'(bus.cmd_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= cmd_op_e;
                data_q <= bus.cmd_data;
                fill_q <= bus.cmd_fill;
            end
        end
    end

    // Zero-count shifts and the reserved opcode skip EXEC so q is never touched
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op_e == OP_RSVD ||
                        (!is_load_op(cmd_op_e) && bus.cmd_cnt == '0)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = is_load_op(cmd_op_e) ? CNT_W'(1) : bus.cmd_cnt;
                    end
                end
            end
            ST_EXEC: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset loads zero because the register itself has no reset
    always_comb begin
        mode       = MODE_HOLD;
        sr_data_in = '0;
        msb_in     = 1'b0;
        lsb_in     = 1'b0;
        if (rst) begin
            mode = MODE_LOAD;
        end else if (state_q == ST_EXEC && !bus.abort) begin
            case (op_q)
                OP_LOAD: begin
                    mode       = MODE_LOAD;
                    sr_data_in = data_q;
                end
                OP_CLR:  mode = MODE_LOAD;
                OP_SHL: begin
                    mode   = MODE_SHL;
                    lsb_in = fill_q;
                end
                OP_SHR: begin
                    mode   = MODE_SHR;
                    msb_in = fill_q;
                end
                OP_ROL: begin
                    mode   = MODE_SHL;
                    lsb_in = sr_q[WIDTH-1];
                end
                OP_ROR: begin
                    mode   = MODE_SHR;
                    msb_in = sr_q[0];
                end
                OP_ASR: begin
                    mode   = MODE_SHR;
                    msb_in = sr_q[WIDTH-1];
                end
                default: mode = MODE_HOLD;
            endcase
        end
    end

    shiftreg_seq_ctrl_shiftreg #(
        .WIDTH(WIDTH)
    ) u_shiftreg (
        .data_in (sr_data_in),
        .MSB_in  (msb_in),
        .LSB_in  (lsb_in),
        .s1      (mode[1]),
        .s0      (mode[0]),
        .clk     (clk),
        .data_out(sr_q)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = (state_q == ST_DONE) && (op_q == OP_RSVD);
    assign bus.q         = sr_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench for shiftreg_seq_ctrl: stimulus pushes expected q/err/done-cycle
// into a scoreboard, a negedge monitor pops and compares on every done pulse.
module tb_shiftreg_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             err;
        int               cyc;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    shiftreg_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shiftreg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Any done pulse with nothing outstanding is itself an error
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check_output({mon_e.name, "_q"}, 32'(bus.q), 32'(mon_e.q));
                check_output({mon_e.name, "_err"}, 32'(bus.err), 32'(mon_e.err));
                check_output({mon_e.name, "_done_cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic apply_stimulus(input string name, input logic [2:0] op, input logic [2:0] cnt,
                                  input logic [3:0] data, input logic fill,
                                  input logic [3:0] exp_q, input logic exp_err,
                                  input int lat, input bit expect_done);
        int waited = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s_ready_timeout: got cmd_ready low for %0d cycles expected high", name, waited);
            return;
        end
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_data  = data;
        bus.cmd_fill  = fill;
        bus.cmd_valid = 1'b1;
        if (expect_done) sb.push_back('{exp_q, exp_err, cyc + lat, name});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.cmd_ready !== 1'b1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s_drain_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] vals [3];
        vals[0] = 4'b0110;
        vals[1] = 4'b1001;
        vals[2] = 4'b0011;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_cnt   = '0;
        bus.cmd_data  = '0;
        bus.cmd_fill  = 1'b0;
        bus.abort     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_q", 32'(bus.q), 32'h0);
        check_output("reset_ready", 32'(bus.cmd_ready), 32'h1);
        check_output("reset_busy", 32'(bus.busy), 32'h0);
        check_output("reset_done", 32'(bus.done), 32'h0);
        check_output("reset_err", 32'(bus.err), 32'h0);
        rst = 1'b0;

        apply_stimulus("load", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        @(negedge clk);
        check_output("load_ready_low1", 32'(bus.cmd_ready), 32'h0);
        check_output("load_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        check_output("load_ready_low2", 32'(bus.cmd_ready), 32'h0);
        @(negedge clk);
        check_output("load_ready_back", 32'(bus.cmd_ready), 32'h1);
        wait_idle("load");

        apply_stimulus("rol1", 3'b100, 3'd1, 4'b0000, 1'b0, 4'b0111, 1'b0, 2, 1'b1);
        wait_idle("rol1");

        apply_stimulus("load2", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        apply_stimulus("asr1", 3'b110, 3'd1, 4'b0000, 1'b0, 4'b1101, 1'b0, 2, 1'b1);
        wait_idle("asr1");

        apply_stimulus("load3", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        apply_stimulus("shr2", 3'b011, 3'd2, 4'b0000, 1'b0, 4'b0010, 1'b0, 3, 1'b1);
        wait_idle("shr2");

        apply_stimulus("load4", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        apply_stimulus("ror4", 3'b101, 3'd4, 4'b0000, 1'b0, 4'b1011, 1'b0, 5, 1'b1);
        @(negedge clk);
        check_output("ror4_busy", 32'(bus.busy), 32'h1);
        wait_idle("ror4");

        apply_stimulus("load5", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        apply_stimulus("shl2_fill1", 3'b010, 3'd2, 4'b0000, 1'b1, 4'b1111, 1'b0, 3, 1'b1);
        apply_stimulus("shl0", 3'b010, 3'd0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1, 1'b1);
        apply_stimulus("rsvd", 3'b111, 3'd3, 4'b0101, 1'b1, 4'b1111, 1'b1, 1, 1'b1);
        apply_stimulus("clr", 3'b001, 3'd5, 4'b1010, 1'b1, 4'b0000, 1'b0, 2, 1'b1);
        wait_idle("clr");

        // Abort after the first shift: partial result kept, no done
        apply_stimulus("abort_shl", 3'b010, 3'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check_output("abort_q", 32'(bus.q), 32'b0001);
        check_output("abort_ready", 32'(bus.cmd_ready), 32'h1);
        check_output("abort_busy", 32'(bus.busy), 32'h0);
        repeat (6) @(negedge clk);

        apply_stimulus("load6", 3'b000, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2, 1'b1);
        wait_idle("load6");
        apply_stimulus("rst_ror", 3'b101, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_mid_q", 32'(bus.q), 32'h0);
        check_output("rst_mid_busy", 32'(bus.busy), 32'h0);
        check_output("rst_mid_ready", 32'(bus.cmd_ready), 32'h1);
        repeat (6) @(negedge clk);

        // Valid held high: each command taken only once the FSM is back in IDLE
        @(negedge clk);
        bus.cmd_op    = 3'b000;
        bus.cmd_cnt   = 3'd0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.cmd_data = vals[k];
            check_output($sformatf("b2b%0d_ready", k), 32'(bus.cmd_ready), 32'h1);
            sb.push_back('{vals[k], 1'b0, cyc + 2, $sformatf("b2b%0d", k)});
            if (k == 2) begin
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
                check_output($sformatf("b2b%0d_ready_low1", k), 32'(bus.cmd_ready), 32'h0);
                @(negedge clk);
                check_output($sformatf("b2b%0d_ready_low2", k), 32'(bus.cmd_ready), 32'h0);
                @(negedge clk);
            end
        end
        wait_idle("b2b");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
